// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule generator: loads one 512-bit block as 16
// big-endian words, then streams W0..W(ROUNDS-1) to the round engine,
// expanding in place inside a 16-word sliding window.
//
// state  | meaning
// IDLE   | waiting for M0, in_ready high
// LOAD   | accepting M1..M15 into the window
// EXPAND | presenting W(out_cnt) = win[0], shifting on each handshake
module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_w,
  output logic [5:0]  out_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  state_t      state;
  logic [31:0] win [16];
  logic [3:0]  load_cnt;
  logic [5:0]  out_cnt;
  logic [31:0] next_w;
  logic        in_hs;
  logic        out_hs;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // win[k] holds W(out_cnt+k), so this is W(out_cnt+16)
  assign next_w = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

  assign in_hs   = in_valid & in_ready;
  assign out_hs  = out_valid & out_ready;
  assign out_w   = win[0];
  assign out_idx = out_cnt;

  // Control FSM, window storage and registered handshake/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      load_cnt  <= '0;
      out_cnt   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_hs) begin
            win[0]   <= in_word;
            load_cnt <= 4'd1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (in_hs) begin
            win[load_cnt] <= in_word;
            load_cnt      <= load_cnt + 4'd1;
            if (load_cnt == 4'd15) begin
              out_cnt   <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= EXPAND;
            end
          end
        end
        EXPAND: begin
          if (out_hs) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= next_w;
            out_cnt <= out_cnt + 6'd1;
            if (out_cnt == LAST_IDX) begin
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Randomized self-checking bench for sha256_msg_schedule: a 64-round and a
// 16-round instance, checked against a direct SHA-256 schedule recurrence.
module tb_sha256_msg_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_word;
  logic        out_ready;
  logic        sel16;

  logic        a_in_ready, a_out_valid, a_busy, a_done;
  logic [31:0] a_out_w;
  logic [5:0]  a_out_idx;
  logic        b_in_ready, b_out_valid, b_busy, b_done;
  logic [31:0] b_out_w;
  logic [5:0]  b_out_idx;

  logic        in_ready, out_valid, busy, done;
  logic [31:0] out_w;
  logic [5:0]  out_idx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] msg   [16];
  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];

  always #5 clk = ~clk;

  sha256_msg_schedule #(.ROUNDS(64)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid & ~sel16),
    .in_ready  (a_in_ready),
    .in_word   (in_word),
    .out_valid (a_out_valid),
    .out_ready (out_ready & ~sel16),
    .out_w     (a_out_w),
    .out_idx   (a_out_idx),
    .busy      (a_busy),
    .done      (a_done)
  );

  sha256_msg_schedule #(.ROUNDS(16)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid & sel16),
    .in_ready  (b_in_ready),
    .in_word   (in_word),
    .out_valid (b_out_valid),
    .out_ready (out_ready & sel16),
    .out_w     (b_out_w),
    .out_idx   (b_out_idx),
    .busy      (b_busy),
    .done      (b_done)
  );

  assign in_ready  = sel16 ? b_in_ready  : a_in_ready;
  assign out_valid = sel16 ? b_out_valid : a_out_valid;
  assign out_w     = sel16 ? b_out_w     : a_out_w;
  assign out_idx   = sel16 ? b_out_idx   : a_out_idx;
  assign busy      = sel16 ? b_busy      : a_busy;
  assign done      = sel16 ? b_done      : a_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule straight from the textbook recurrence over all 64 words
  task automatic compute_schedule();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = msg[t];
      else exp_w[t] = (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                      + exp_w[t-7]
                      + (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                      + exp_w[t-16];
    end
  endtask

  task automatic random_msg();
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    compute_schedule();
  endtask

  // Called at a negedge; returns at the negedge after the n-th accepted word
  task automatic load_block(input int n, input bit gaps);
    int idx = 0;
    int cyc = 0;
    while (idx < n) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_word  = in_valid ? msg[idx] : $urandom;
      check("load_out_valid", out_valid, 0);
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      cyc++;
      if (cyc > 400) begin
        check("load_timeout", idx, n);
        break;
      end
    end
    in_valid = 1'b0;
    if (!gaps && n == 16) check("load_cycles", cyc, 16);
    if (n == 16) begin
      check("w0_presented", out_valid, 1);
      check("expand_in_ready", in_ready, 0);
    end
  endtask

  // Called at a negedge in EXPAND; takes n_take words, ends at the done cycle
  task automatic collect(input int rounds, input int n_take, input bit bp);
    int t = 0;
    int cyc = 0;
    while (t < n_take) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = 1'($urandom_range(0, 1));
      in_word   = $urandom;
      check("exp_in_ready", in_ready, 0);
      check("exp_out_valid", out_valid, 1);
      check("exp_busy", busy, 1);
      check("exp_done", done, 0);
      check("out_w", out_w, exp_w[t]);
      check("out_idx", out_idx, t);
      if (out_ready) begin
        got_w[t] = out_w;
        t++;
      end
      @(negedge clk);
      cyc++;
      if (cyc > 1000) begin
        check("collect_timeout", t, n_take);
        break;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (n_take == rounds) begin
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
      check("done_in_ready", in_ready, 1);
      check("done_out_valid", out_valid, 0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_w"}, out_w, 0);
    check({tag, "_out_idx"}, out_idx, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_word = '0; out_ready = 1'b0; sel16 = 1'b0;
    #3;
    check_reset_values("por");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // "abc" block, no stalls
    for (int i = 0; i < 16; i++) msg[i] = '0;
    msg[0] = 32'h61626380;
    msg[15] = 32'h00000018;
    compute_schedule();
    load_block(16, 0);
    collect(64, 64, 0);
    check("abc_w16", got_w[16], 32'h61626380);
    check("abc_w17", got_w[17], 32'h000F0000);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    // Random blocks with input gaps and output backpressure
    for (int k = 0; k < 3; k++) begin
      random_msg();
      load_block(16, 1);
      collect(64, 64, 1);
      @(negedge clk);
    end

    // Reset after 7 loaded words, then a clean block
    random_msg();
    load_block(7, 1);
    #2 rst = 1'b1;
    #1 check_reset_values("rst_load");
    @(negedge clk);
    rst = 1'b0;
    random_msg();
    load_block(16, 0);
    collect(64, 64, 1);
    @(negedge clk);

    // Reset in the middle of expansion
    random_msg();
    load_block(16, 0);
    collect(64, 10, 1);
    #2 rst = 1'b1;
    #1 check_reset_values("rst_expand");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("no_done_after_abort", done, 0);

    // Back-to-back: next M0 presented on the done cycle
    random_msg();
    load_block(16, 0);
    collect(64, 64, 0);
    random_msg();
    load_block(16, 0);
    collect(64, 64, 1);
    @(negedge clk);

    // ROUNDS=16 instance: only the raw message words come out
    sel16 = 1'b1;
    @(negedge clk);
    random_msg();
    load_block(16, 1);
    collect(16, 16, 1);
    @(negedge clk);
    check("r16_done_fell", done, 0);
    check("r16_idle_out_valid", out_valid, 0);
    sel16 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- SHA-256 message-schedule generator. It is the producer side of the round datapath's W input.
- Accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready stream.
- Streams W0..W(ROUNDS-1) to the compression round engine, one word per accepted handshake.
- Expansion runs in place in a 16-word sliding window using the small sigma functions.

Parameters:
ROUNDS, 64, number of schedule words emitted per block; legal range 16..64.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_word holds a message word
in_ready  output  1  block can accept a message word this cycle
in_word  input  32  message word; first word accepted is M0
out_valid  output  1  out_w / out_idx hold schedule word W(out_idx)
out_ready  input  1  round engine consumes the word this cycle
out_w  output  32  schedule word W_t
out_idx  output  6  round index t of out_w
busy  output  1  high from first accepted input word until last output handshake
done  output  1  one-cycle pulse after handshake of W(ROUNDS-1)

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high and applies immediately regardless of clk.
- Reset values:
  - state=IDLE; load_cnt=0; out_cnt=0; window cleared to 0.
  - in_ready=1, out_valid=0, out_w=0, out_idx=0, busy=0, done=0.
- States: IDLE, LOAD, EXPAND.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: write in_word into win[0], set load_cnt=1, go to LOAD.
- LOAD:
  - in_ready=1.
  - Each handshake writes win[load_cnt] and increments load_cnt.
  - The handshake of the 16th word (load_cnt==15) goes to EXPAND with out_cnt=0.
  - No output activity in LOAD.
- EXPAND:
  - in_ready=0; in_valid is ignored.
  - out_valid=1, out_w=win[0], out_idx=out_cnt. All three are driven directly from registers.
  - On out_valid&out_ready:
    - Shift the window: win[i]<=win[i+1] for i=0..14.
    - Load win[15] <= sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], all mod 2^32.
    - Increment out_cnt.
  - Invariant: win[k] holds W(out_cnt+k). The computed word is W(out_cnt+16). Words past ROUNDS-1 may be computed; they are never emitted.
  - On the handshake with out_cnt==ROUNDS-1: go to IDLE, pulse done for exactly the next cycle, busy falls.
- Small sigma functions:
  - sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- Stall: when out_ready=0 in EXPAND, out_w, out_idx and the window hold unchanged indefinitely.
- Throughput:
  - One word per cycle while out_ready=1.
  - W0 is presented the cycle after the 16th input handshake.
  - Back-to-back blocks: the next block's M0 can be accepted the cycle done is high.
- busy = (state != IDLE).
- Reset mid-operation, in LOAD or EXPAND: immediate return to reset values. The partial block is discarded; no done pulse.
- ROUNDS=16: EXPAND emits W0..W15 only, with no expanded words.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> in_ready=1, out_valid=0, out_w=0, busy=0, done=0 with no clk edge.
- "abc" block: M0=0x61626380, M1..M14=0, M15=0x00000018, out_ready=1 -> W0..W15 equal the inputs. W16=0x61626380, W17=0x000F0000. W18..W63 match the software SHA-256 schedule. out_idx runs 0..63. done is high for 1 cycle. Total 64 output handshakes.
- Input gaps and backpressure: toggle in_valid randomly while loading; toggle out_ready with 50% random duty during EXPAND -> identical W sequence. While out_ready=0, out_w and out_idx stay stable. in_ready=0 throughout EXPAND.
- Reset after 7 loaded words -> busy=0. A fresh 16-word load afterwards produces the correct schedule, with no contamination from the aborted words.
- Back-to-back: the second block's M0 is presented on the done cycle -> it is accepted. Second-block W0 appears 16 input handshakes later, and its schedule is correct.
- ROUNDS=16 build: load 16 words -> exactly 16 outputs equal to the inputs. done fires after W15.
